// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control sequencer for the MIPS datapath core.
// Fetches over a variable-latency imem handshake, decodes opcode/funct and
// steps FETCH->DECODE->EXEC->MEM->WB, driving core control lines per state.
// Counts retired instructions; halts (sticky) on illegal encodings or timeouts.
module mips_mc_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_next,
  output logic [1:0]  o_reg_dst,
  output logic        o_alu_src,
  output logic [1:0]  o_alu_ctrl,
  output logic        o_reg_we,
  output logic [1:0]  o_reg_in,
  output logic        o_mem_we,
  output logic        o_beq,
  output logic        o_bne,
  output logic [31:0] o_retired,
  output logic        o_halted,
  output logic [1:0]  o_err
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_ADDI, C_XORI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } cls_t;

  state_t          r_state;
  state_t          w_state_next;
  cls_t            w_cls;
  logic [5:0]      r_opcode;
  logic [5:0]      r_funct;
  logic [WCW-1:0]  r_wait_cnt;
  logic [31:0]     r_retired;
  logic            r_halted;
  logic [1:0]      r_err;
  logic            w_alu_src;
  logic [1:0]      w_alu_ctrl;
  logic            w_waiting;
  logic            w_unused;

  // Instruction fields between rs and funct are the datapath's business.
  assign w_unused = ^i_imem_rdata[25:6];

  // Classify the held opcode/funct into one instruction kind.
  always_comb begin
    w_cls = C_ILL;
    case (r_opcode)
      6'h00: begin
        case (r_funct)
          6'h20, 6'h22, 6'h2A: w_cls = C_RALU;
          6'h08:               w_cls = C_JR;
          default:             w_cls = C_ILL;
        endcase
      end
      6'h23:   w_cls = C_LW;
      6'h2B:   w_cls = C_SW;
      6'h04:   w_cls = C_BEQ;
      6'h05:   w_cls = C_BNE;
      6'h08:   w_cls = C_ADDI;
      6'h0E:   w_cls = C_XORI;
      6'h02:   w_cls = C_J;
      6'h03:   w_cls = C_JAL;
      default: w_cls = C_ILL;
    endcase
  end

  // ALU operand select and operation, held from EXEC through MEM and WB.
  always_comb begin
    w_alu_src  = 1'b0;
    w_alu_ctrl = 2'b00;
    case (w_cls)
      C_RALU: begin
        w_alu_src = 1'b1;
        case (r_funct)
          6'h22:   w_alu_ctrl = 2'b01;
          6'h2A:   w_alu_ctrl = 2'b11;
          default: w_alu_ctrl = 2'b00;
        endcase
      end
      C_XORI:       w_alu_ctrl = 2'b10;
      C_BEQ, C_BNE: begin
        w_alu_src  = 1'b1;
        w_alu_ctrl = 2'b01;
      end
      default: ;
    endcase
  end

  // A memory wait cycle: request outstanding and no response this cycle.
  assign w_waiting = ((r_state == S_FETCH) && !i_imem_ready) ||
                     ((r_state == S_MEM) && !i_dmem_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_state_next;
  end

  // Next-state selection; a ready on the threshold cycle wins over timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = S_FETCH;
      S_FETCH: begin
        if (i_imem_ready)               w_state_next = S_DECODE;
        else if (r_wait_cnt == WAIT_LAST) w_state_next = S_HALT;
      end
      S_DECODE: w_state_next = (w_cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (w_cls)
          C_RALU, C_ADDI, C_XORI: w_state_next = S_WB;
          C_LW, C_SW:             w_state_next = S_MEM;
          default:                w_state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (i_dmem_ready)               w_state_next = (w_cls == C_SW) ? S_FETCH : S_WB;
        else if (r_wait_cnt == WAIT_LAST) w_state_next = S_HALT;
      end
      S_WB:     w_state_next = S_FETCH;
      default:  w_state_next = S_HALT;
    endcase
  end

  // Control outputs decoded from state and the held instruction class.
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_next  = 2'b00;
    o_reg_dst  = 2'b00;
    o_alu_src  = 1'b0;
    o_alu_ctrl = 2'b00;
    o_reg_we   = 1'b0;
    o_reg_in   = 2'b00;
    o_mem_we   = 1'b0;
    o_beq      = 1'b0;
    o_bne      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_we    = i_imem_ready;
      end
      S_EXEC: begin
        o_alu_src  = w_alu_src;
        o_alu_ctrl = w_alu_ctrl;
        case (w_cls)
          C_BEQ: begin o_beq = 1'b1; o_pc_we = 1'b1; end
          C_BNE: begin o_bne = 1'b1; o_pc_we = 1'b1; end
          C_J:   begin o_pc_next = 2'b01; o_pc_we = 1'b1; end
          C_JAL: begin
            o_pc_next = 2'b01;
            o_pc_we   = 1'b1;
            o_reg_we  = 1'b1;
            o_reg_dst = 2'b10;
            o_reg_in  = 2'b10;
          end
          C_JR:  begin o_pc_next = 2'b10; o_pc_we = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_alu_src  = w_alu_src;
        o_alu_ctrl = w_alu_ctrl;
        if (w_cls == C_SW) begin
          o_mem_we = 1'b1;
          o_pc_we  = i_dmem_ready;
        end
      end
      S_WB: begin
        o_reg_we   = 1'b1;
        o_pc_we    = 1'b1;
        o_alu_src  = w_alu_src;
        o_alu_ctrl = w_alu_ctrl;
        o_reg_dst  = (w_cls == C_RALU) ? 2'b01 : 2'b00;
        o_reg_in   = (w_cls == C_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // Instruction capture, wait counter, retire counter and halt/error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= '0;
      r_funct    <= '0;
      r_wait_cnt <= '0;
      r_retired  <= '0;
      r_halted   <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      if ((r_state == S_FETCH) && i_imem_ready) begin
        r_opcode <= i_imem_rdata[31:26];
        r_funct  <= i_imem_rdata[5:0];
      end
      if (w_waiting && (w_state_next == r_state)) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                        r_wait_cnt <= '0;
      if (o_pc_we) r_retired <= r_retired + 32'd1;
      if ((w_state_next == S_HALT) && (r_state != S_HALT)) begin
        r_halted <= 1'b1;
        case (r_state)
          S_DECODE: r_err <= 2'b01;
          S_FETCH:  r_err <= 2'b10;
          S_MEM:    r_err <= 2'b11;
          default:  r_err <= 2'b01;
        endcase
      end
    end
  end

  assign o_retired = r_retired;
  assign o_halted  = r_halted;
  assign o_err     = r_err;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each instruction issues an expected
// final-cycle record into a queue; a monitor pops and compares whenever the
// DUT asserts pc_we (retire) or raises halted.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_imem_rdata;
  logic        i_imem_ready;
  logic        i_dmem_ready;
  logic        o_imem_req, o_dmem_req, o_ir_we, o_pc_we;
  logic [1:0]  o_pc_next, o_reg_dst, o_alu_ctrl, o_reg_in, o_err;
  logic        o_alu_src, o_reg_we, o_mem_we, o_beq, o_bne, o_halted;
  logic [31:0] o_retired;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_imem_rdata(i_imem_rdata), .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
    .o_pc_next(o_pc_next), .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_alu_ctrl(o_alu_ctrl),
    .o_reg_we(o_reg_we), .o_reg_in(o_reg_in), .o_mem_we(o_mem_we), .o_beq(o_beq), .o_bne(o_bne),
    .o_retired(o_retired), .o_halted(o_halted), .o_err(o_err)
  );

  typedef struct {
    bit          halt;
    logic [12:0] ctrl;
    int          cyc;
    int          rwe;
    logic [31:0] ret;
    logic [1:0]  err;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          ev_cnt = 0;
  int          halt_viol = 0;
  logic [31:0] model_ret = 0;
  logic [31:0] cfg_word = 0;
  int          cfg_iw = 0;
  int          cfg_dw = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // {pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we, beq, bne}
  function automatic logic [12:0] mk(input logic [1:0] pcn, input logic [1:0] rd,
                                     input logic as, input logic [1:0] ac, input logic rwe,
                                     input logic [1:0] rin, input logic mwe,
                                     input logic bq, input logic bn);
    return {pcn, rd, as, ac, rwe, rin, mwe, bq, bn};
  endfunction

  // Memory responder: ready after cfg_*w wait cycles (negative = never);
  // outside a request, readies are driven high with junk to prove they are ignored.
  int iw_cnt = 0;
  int dw_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (o_imem_req) begin
      i_imem_ready = (cfg_iw >= 0) && (iw_cnt == cfg_iw);
      i_imem_rdata = i_imem_ready ? cfg_word : 32'hFFFF_FFFF;
      iw_cnt++;
    end else begin
      iw_cnt       = 0;
      i_imem_ready = 1'b1;
      i_imem_rdata = 32'hFC00_0000;
    end
    if (o_dmem_req) begin
      i_dmem_ready = (cfg_dw >= 0) && (dw_cnt == cfg_dw);
      dw_cnt++;
    end else begin
      dw_cnt       = 0;
      i_dmem_ready = 1'b1;
    end
  end

  // Monitor: tracks each instruction from its first fetch cycle and scores it.
  bit          in_instr = 0;
  bit          prev_halted = 0;
  bit          ret_pending = 0;
  logic [31:0] ret_exp = 0;
  int          cyc = 0;
  int          rwe_cnt = 0;
  int          mwe_bad = 0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      in_instr = 0; prev_halted = 0; ret_pending = 0;
      cyc = 0; rwe_cnt = 0; mwe_bad = 0; halt_viol = 0;
    end else begin
      if (ret_pending) begin
        chk("retired_count", o_retired, ret_exp);
        ret_pending = 0;
      end
      if (o_halted && !prev_halted) begin
        ev_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          x = q.pop_front();
          $display("event %0d: halt err=%0d cycles=%0d retired=%0d", ev_cnt, o_err, cyc, o_retired);
          chk("halt_expected", x.halt, 1);
          chk("halt_err", o_err, x.err);
          chk("halt_cycles", cyc, x.cyc);
          chk("halt_retired", o_retired, x.ret);
        end
        in_instr = 0;
      end else begin
        if (!in_instr && o_imem_req) begin
          in_instr = 1; cyc = 0; rwe_cnt = 0; mwe_bad = 0;
        end
        if (in_instr) begin
          cyc++;
          if (o_reg_we) rwe_cnt++;
          if (o_mem_we && !o_dmem_req) mwe_bad++;
          if (o_pc_we) begin
            ev_cnt++;
            if (q.size() == 0) begin
              chk("unexpected_retire", 1, 0);
            end else begin
              x = q.pop_front();
              $display("event %0d: retire ctrl=%h cycles=%0d reg_we_cycles=%0d", ev_cnt,
                       {o_pc_next, o_reg_dst, o_alu_src, o_alu_ctrl, o_reg_we, o_reg_in,
                        o_mem_we, o_beq, o_bne}, cyc, rwe_cnt);
              chk("retire_expected", x.halt, 0);
              chk("final_ctrl", {o_pc_next, o_reg_dst, o_alu_src, o_alu_ctrl, o_reg_we,
                                 o_reg_in, o_mem_we, o_beq, o_bne}, x.ctrl);
              chk("instr_cycles", cyc, x.cyc);
              chk("reg_we_cycles", rwe_cnt, x.rwe);
              chk("mem_we_outside_req", mwe_bad, 0);
              ret_exp = x.ret;
              ret_pending = 1;
            end
            in_instr = 0;
          end
        end
      end
      if (o_halted && (o_imem_req || o_dmem_req || o_ir_we || o_pc_we || o_reg_we ||
                       o_mem_we || o_beq || o_bne || o_alu_src || (o_pc_next != 0) ||
                       (o_reg_dst != 0) || (o_alu_ctrl != 0) || (o_reg_in != 0)))
        halt_viol++;
      prev_halted = o_halted;
    end
  end

  // Issue one instruction and wait (bounded) for the monitor to score it.
  task automatic run(input logic [31:0] w, input int iw, input int dw, input bit h,
                     input logic [12:0] c, input int cy, input int rw, input logic [1:0] e);
    exp_t x;
    int target;
    x.halt = h; x.ctrl = c; x.cyc = cy; x.rwe = rw; x.err = e;
    if (!h) model_ret++;
    x.ret = model_ret;
    q.push_back(x);
    cfg_word = w; cfg_iw = iw; cfg_dw = dw;
    target = ev_cnt + 1;
    for (int g = 0; g < 100 && ev_cnt < target; g++) @(posedge clk);
    chk("event_arrived", (ev_cnt >= target), 1);
  endtask

  task automatic check_reset_state();
    chk("rst_retired", o_retired, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_err", o_err, 0);
    chk("rst_outputs", {o_imem_req, o_dmem_req, o_ir_we, o_pc_we, o_pc_next, o_reg_dst,
                        o_alu_src, o_alu_ctrl, o_reg_we, o_reg_in, o_mem_we, o_beq, o_bne}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_ret = 0;
    @(negedge clk);
    check_reset_state();
    chk("queue_drained", q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_imem_rdata = '0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    //   word          iw dw halt ctrl at final cycle                  cyc rwe err
    run(32'h00221820,  0, 0, 0, mk(2'd0,2'd1,1,2'd0,1,2'd0,0,0,0),   4, 1, 2'd0); // ADD
    run(32'h8C220004,  0, 3, 0, mk(2'd0,2'd0,0,2'd0,1,2'd1,0,0,0),   8, 1, 2'd0); // LW 3 waits
    run(32'hAC220008,  0, 1, 0, mk(2'd0,2'd0,0,2'd0,0,2'd0,1,0,0),   5, 0, 2'd0); // SW 1 wait
    run(32'h10220003,  0, 0, 0, mk(2'd0,2'd0,1,2'd1,0,2'd0,0,1,0),   3, 0, 2'd0); // BEQ
    run(32'h0C000010,  0, 0, 0, mk(2'd1,2'd2,0,2'd0,1,2'd2,0,0,0),   3, 1, 2'd0); // JAL
    run(32'h00221822,  2, 0, 0, mk(2'd0,2'd1,1,2'd1,1,2'd0,0,0,0),   6, 1, 2'd0); // SUB 2 imem waits
    run(32'h0022182A,  0, 0, 0, mk(2'd0,2'd1,1,2'd3,1,2'd0,0,0,0),   4, 1, 2'd0); // SLT
    run(32'h3822FFFF,  0, 0, 0, mk(2'd0,2'd0,0,2'd2,1,2'd0,0,0,0),   4, 1, 2'd0); // XORI
    run(32'h20220005,  3, 0, 0, mk(2'd0,2'd0,0,2'd0,1,2'd0,0,0,0),   7, 1, 2'd0); // ADDI ready on threshold
    run(32'h14220002,  0, 0, 0, mk(2'd0,2'd0,1,2'd1,0,2'd0,0,0,1),   3, 0, 2'd0); // BNE
    run(32'h08000040,  0, 0, 0, mk(2'd1,2'd0,0,2'd0,0,2'd0,0,0,0),   3, 0, 2'd0); // J
    run(32'h03E00008,  0, 0, 0, mk(2'd2,2'd0,0,2'd0,0,2'd0,0,0,0),   3, 0, 2'd0); // JR
    run(32'hFC000000,  0, 0, 1, 13'd0,                               2, 0, 2'd1); // opcode 0x3F
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("halt_quiet_20", halt_viol, 0);
    chk("halt_sticky", o_halted, 1);
    chk("halt_err_held", o_err, 1);
    chk("halt_retired_held", o_retired, 12);

    do_reset();
    run(32'h00221820, -1, 0, 1, 13'd0,                               4, 0, 2'd2); // imem timeout
    do_reset();
    run(32'h8C220004,  0,-1, 1, 13'd0,                               7, 0, 2'd3); // dmem timeout
    do_reset();
    run(32'h00221820,  0, 0, 0, mk(2'd0,2'd1,1,2'd0,1,2'd0,0,0,0),   4, 1, 2'd0); // restart ADD
    run(32'h00221821,  0, 0, 1, 13'd0,                               2, 0, 2'd1); // bad funct

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_retired", o_retired, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control sequencer for the single-cycle MIPS datapath core. It fetches each instruction over a variable-latency instruction-memory handshake and decodes opcode/funct. It then drives the core's control inputs (pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we, beq, bne) plus PC/IR write enables across FETCH→DECODE→EXEC→MEM→WB. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
- TIMEOUT, 256: consecutive unanswered request cycles before a timeout halt (≥2).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  instruction-memory response strobe.
- dmem_ready  in  1  data-memory response strobe (load data valid / store done).
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- ir_we  out  1  external IR latches imem_rdata.
- pc_we  out  1  PC register loads core pcRes.
- pc_next  out  2  00 pc+4/branch, 01 jump, 10 jr (regDataA).
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- alu_src  out  1  0 sign-extended imm, 1 regDataB.
- alu_ctrl  out  2  00 add, 01 sub, 10 xor, 11 slt.
- reg_we  out  1  register-file write enable.
- reg_in  out  2  00 ALU, 01 memory, 10 pc+4 (link).
- mem_we  out  1  data-memory write enable.
- beq, bne  out  1 each  branch qualifiers to core.
- retired  out  32  retired-instruction count.
- halted  out  1  sticky halt flag.
- err  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT. All control outputs are decoded from state plus the internally held opcode/funct. They are 0 in any state not listed below.
- RESET → FETCH on first edge after rst_n rises.
- FETCH: imem_req=1. On imem_ready: ir_we=1, opcode/funct captured internally, → DECODE.
- DECODE: one cycle. Illegal encoding → HALT, err=01.
- Legal: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E, J 0x02, JAL 0x03; R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- EXEC behaviour by instruction:
  - R-ALU: alu_src=1; alu_ctrl per funct; → WB.
  - ADDI/XORI: alu_src=0; alu_ctrl 00/10; → WB.
  - LW/SW: alu_src=0, alu_ctrl=00; → MEM.
  - BEQ/BNE: alu_src=1, alu_ctrl=01, beq/bne=1, pc_next=00, pc_we=1; → FETCH.
  - J: pc_next=01, pc_we=1; → FETCH.
  - JAL: additionally reg_we=1, reg_dst=10, reg_in=10; → FETCH.
  - JR: pc_next=10, pc_we=1; → FETCH.
- MEM: dmem_req=1, ALU controls held as in EXEC. For SW, mem_we=1 while dmem_req=1.
  - On dmem_ready, SW: pc_we=1 (pc_next=00, beq=bne=0), → FETCH.
  - On dmem_ready, LW: → WB.
- WB: reg_we=1, pc_we=1, pc_next=00, ALU controls held.
  - R-type: reg_dst=01, reg_in=00.
  - ADDI/XORI: reg_dst=00, reg_in=00.
  - LW: reg_dst=00, reg_in=01.
  - → FETCH.
- retired increments by 1 on every cycle with pc_we=1 and wraps at 2^32−1→0.
- Wait counter: counts FETCH/MEM cycles with request high and ready low. It clears on ready or state change. When it reaches TIMEOUT−1 with ready still low, → HALT with err=10 (FETCH) or 11 (MEM).
- HALT: halted=1, err held, all control outputs 0. Left only by reset.

## Timing
- Reset (async assert): state=RESET, retired=0, halted=0, err=00, wait counter=0, every output 0.
- Ready sampled only while the matching request is high. A ready in the first request cycle is accepted (zero-wait). Ready outside its request is ignored.
- Instruction cycles with zero-wait memory:
  - Branch/jump: 3 (FETCH, DECODE, EXEC).
  - ALU ops and SW: 4.
  - LW: 5.
- Each memory wait cycle adds one cycle.
- pc_we is asserted exactly once per instruction, in its final cycle. reg_we is asserted at most once per instruction.
- Ready arriving on the same edge as the timeout threshold: ready wins and there is no halt.
- rst_n assertion mid-instruction aborts immediately. There is no PC/register/memory write after the assert edge.

## Test plan
- Reset then ADD $3,$1,$2 (0x00221820), zero-wait imem → imem_req cycle 1; EXEC alu_src=1, alu_ctrl=00; WB reg_we=1, reg_dst=01, pc_we=1 on cycle 4; retired=1.
- LW 0x8C220004, dmem_ready after 3 wait cycles → MEM lasts 4 cycles, then WB reg_in=01, reg_dst=00; total 8 cycles.
- SW 0xAC220008 → mem_we=1 only while dmem_req=1; reg_we stays 0; pc_we in final MEM cycle.
- BEQ 0x10220003 then JAL 0x0C000010 → BEQ: EXEC beq=1, alu_ctrl=01, pc_we=1. JAL: reg_we=1, reg_dst=10, reg_in=10, pc_next=01. retired=2.
- Opcode 0x3F fetched → HALT after DECODE, halted=1, err=01, imem_req stays 0 for 20 cycles.
- TIMEOUT=4, imem_ready held low → halt after 4 request cycles, err=10. Then rst_n pulse → retired=0, err=00, fetch restarts.
